// File: rtl/riscv_ctrl_pkg.sv
// Shared ISA constants for the multi-cycle core: opcodes, control FSM state
// encodings and PC-select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    CTRL_RESET   = 3'd0,
    CTRL_FETCH   = 3'd1,
    CTRL_DECODE  = 3'd2,
    CTRL_EXECUTE = 3'd3,
    CTRL_MEM     = 3'd4,
    CTRL_WB      = 3'd5,
    CTRL_TRAP    = 3'd6
  } ctrl_state_e;

  localparam logic [1:0] PCSEL_NEXT   = 2'd0;
  localparam logic [1:0] PCSEL_TARGET = 2'd1;
  localparam logic [1:0] PCSEL_TRAP   = 2'd2;

endpackage

// File: rtl/riscv_ctrl.sv
// Multi-cycle control FSM: fetch / decode / execute / mem / writeback / trap
// sequencing, PC update control and retired-instruction counter.
module riscv_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic            id_exception,
  input  logic            branch_taken,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            ir_we,
  output logic            id_en,
  output logic            ex_en,
  output logic            rf_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            trap,
  output logic [XLEN-1:0] instret
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            retire;

  logic is_load, is_store, is_branch, is_jump;
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CTRL_RESET;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_RESET:   state_d = CTRL_FETCH;
      CTRL_FETCH:   if (imem_ack) state_d = CTRL_DECODE;
      CTRL_DECODE:  state_d = CTRL_EXECUTE;
      CTRL_EXECUTE: begin
        if (id_exception)            state_d = CTRL_TRAP;
        else if (is_load || is_store) state_d = CTRL_MEM;
        else                          state_d = CTRL_WB;
      end
      CTRL_MEM:     if (dmem_ack) state_d = is_store ? CTRL_FETCH : CTRL_WB;
      CTRL_WB:      state_d = CTRL_FETCH;
      CTRL_TRAP:    state_d = CTRL_FETCH;
      default:      state_d = CTRL_RESET;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PCSEL_NEXT;
    trap     = 1'b0;
    retire   = 1'b0;
    case (state_q)
      CTRL_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      CTRL_DECODE:  id_en = 1'b1;
      CTRL_EXECUTE: ex_en = 1'b1;
      CTRL_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        // Stores retire straight out of MEM; they have nothing to write back.
        if (dmem_ack && is_store) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      CTRL_WB: begin
        rf_we  = !(is_branch || is_store);
        pc_we  = 1'b1;
        pc_sel = (is_jump || (is_branch && branch_taken)) ? PCSEL_TARGET : PCSEL_NEXT;
        retire = 1'b1;
      end
      CTRL_TRAP: begin
        pc_we  = 1'b1;
        pc_sel = PCSEL_TRAP;
        trap   = 1'b1;
      end
      default: ;
    endcase
  end

  assign instret_d = retire ? instret_q + {{(XLEN-1){1'b0}}, 1'b1} : instret_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_riscv_ctrl.sv
// Directed bench for riscv_ctrl: per-cycle expected output vectors are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_riscv_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] ADD = 7'b0110011;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        id_en;
    logic        ex_en;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [31:0] instret;
  } obs_t;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic        id_exception, branch_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, id_en, ex_en, rf_we, pc_we, trap;
  logic [1:0]  pc_sel;
  logic [31:0] instret;

  riscv_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .id_exception(id_exception),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .id_en(id_en), .ex_en(ex_en), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic [31:0] exp_cnt = 0;

  always @(negedge clk) begin
    obs_t  a, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{imem_req, dmem_req, dmem_we, ir_we, id_en, ex_en, rf_we, pc_we,
            pc_sel, trap, instret};
      n_cmp++;
      assert (a === e) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", t, a, e);
      end
      n_cmp++;
      assert ($onehot0({id_en, ex_en, rf_we, ir_we})) else begin
        n_mis++;
        $error("FAIL %s_onehot: observed %b expected one-hot-or-zero", t,
               {id_en, ex_en, rf_we, ir_we});
      end
    end
  end

  function automatic obs_t z();
    obs_t r;
    r = '0;
    r.instret = exp_cnt;
    return r;
  endfunction

  task automatic step(input logic ia, input logic da, input logic exc,
                      input logic bt, input obs_t e, input string t);
    imem_ack = ia; dmem_ack = da; id_exception = exc; branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int waits, input string t);
    obs_t e;
    e = z(); e.imem_req = 1'b1;
    for (int i = 0; i < waits; i++) step(1'b0, 1'b1, 1'b0, 1'b0, e, {t, "_fwait"});
    e.ir_we = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, e, {t, "_fack"});
  endtask

  task automatic run(input logic [6:0] op, input int fw, input logic exc,
                     input int mw, input logic bt, input string t);
    obs_t e;
    logic st, br;
    st = (op == SW);
    br = (op == BR);
    opcode = op;
    fetch(fw, t);
    // stray acks in DECODE must be ignored
    e = z(); e.id_en = 1'b1;
    step(1'b1, 1'b1, exc, 1'b0, e, {t, "_dec"});
    e = z(); e.ex_en = 1'b1;
    step(1'b0, 1'b0, exc, 1'b0, e, {t, "_exe"});
    if (exc) begin
      e = z(); e.pc_we = 1'b1; e.pc_sel = 2'd2; e.trap = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, e, {t, "_trap"});
      return;
    end
    if (op == LW || st) begin
      e = z(); e.dmem_req = 1'b1; e.dmem_we = st;
      for (int i = 0; i < mw; i++) step(1'b1, 1'b0, 1'b0, 1'b0, e, {t, "_mwait"});
      if (st) e.pc_we = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0, e, {t, "_mack"});
      if (st) begin
        exp_cnt++;
        return;
      end
    end
    e = z();
    e.rf_we  = !(br || st);
    e.pc_we  = 1'b1;
    e.pc_sel = (op == JAL || op == JLR || (br && bt)) ? 2'd1 : 2'd0;
    step(1'b0, 1'b0, 1'b0, bt, e, {t, "_wb"});
    exp_cnt++;
  endtask

  initial begin
    obs_t e;
    rst = 1'b1; opcode = 7'd0; id_exception = 1'b0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b0, 1'b0, z(), "reset_hold");
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, z(), "reset_state");

    run(ADD, 2, 1'b0, 0, 1'b1, "add");
    run(LW,  0, 1'b0, 3, 1'b0, "lw");
    run(SW,  1, 1'b0, 0, 1'b0, "sw");
    run(BR,  0, 1'b0, 0, 1'b1, "beq_t");
    run(BR,  0, 1'b0, 0, 1'b0, "beq_nt");
    run(JAL, 0, 1'b0, 0, 1'b0, "jal");
    run(JLR, 0, 1'b0, 0, 1'b0, "jalr");
    run(7'd0, 0, 1'b1, 0, 1'b0, "exc");
    run(7'h7f, 0, 1'b0, 0, 1'b0, "unk");

    // Async reset while a load sits in MEM
    opcode = LW;
    fetch(0, "rmem");
    e = z(); e.id_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "rmem_dec");
    e = z(); e.ex_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "rmem_exe");
    imem_ack = 1'b0; dmem_ack = 1'b0;
    e = z(); e.dmem_req = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back("rmem_mem");
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    assert (dmem_req === 1'b0) else begin
      n_mis++;
      $error("FAIL rst_dmem_req: observed %b expected 0", dmem_req);
    end
    n_cmp++;
    assert (instret === 32'd0) else begin
      n_mis++;
      $error("FAIL rst_instret: observed %0d expected 0", instret);
    end
    exp_cnt = 0;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b0, 1'b0, z(), "rst_hold2");
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, z(), "rst_state2");
    run(ADD, 1, 1'b0, 0, 1'b0, "add_post_rst");

    @(posedge clk); #1;
    n_cmp++;
    assert (exp_q.size() === 0) else begin
      n_mis++;
      $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
